mem_uart_dump_ctrl: RTL and testbench

Command-driven sequencer that streams a block of words from the 16-bit synchronous-read buffer RAM out over the UART TX byte port.
It accepts a command (start address, word count, byte mode), walks the RAM addresses, captures each word, and emits its low byte and optionally its high byte through the valid/ack UART handshake.
It sits between the host/SPI command decoder and the shared buffer RAM read port plus UART TX, and replaces fixed-range test dumps.

---
 rtl/dump_pkg.sv | 20 ++
 rtl/uart_byte_hs.sv | 33 +++
 rtl/mem_uart_dump_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mem_uart_dump_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dump_pkg.sv
// Shared constants and state encoding for the RAM-to-UART dump sequencer.
package dump_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  // Byte-select values for the word being sent.
  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    CAPT  = 3'd2,
    TX_LO = 3'd3,
    TX_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/uart_byte_hs.sv
// One-byte valid/ack holding register in front of the UART TX byte port.
module uart_byte_hs (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       ack,
  output logic       valid,
  output logic [7:0] data,
  output logic       xfer
);

  logic       valid_r;
  logic [7:0] data_r;

  assign xfer  = valid_r & ack;
  assign valid = valid_r;
  assign data  = data_r;

  // Byte holding register: data only changes on load, so it is frozen while valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= 8'h00;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= din;
    end else if (xfer) begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_uart_dump_ctrl.sv
// Command-driven sequencer streaming a block of RAM words out over the UART TX byte port.
module mem_uart_dump_ctrl #(
  parameter int ADDR_W = dump_pkg::ADDR_W,
  parameter int DATA_W = dump_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              cmd_both,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              uart_valid,
  output logic [7:0]        uart_data,
  input  logic              uart_ack,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  import dump_pkg::*;

  localparam logic [ADDR_W-1:0] ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ZERO = {ADDR_W{1'b0}};

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] addr_r, rem_r;
  logic              mode_r, abort_pend_r;
  logic [7:0]        hi_r;
  logic              done_r, aborted_r, busy_r, ready_r;

  logic       accept_s, load_s, sel_s, addr_inc_s, rem_dec_s;
  logic       abort_set_s, fin_abort_s, word_end_s, xfer_s;
  logic [7:0] byte_s;

  assign mem_addr  = addr_r;
  assign cmd_ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign aborted   = aborted_r;

  // The low byte goes straight from the RAM bus; only the high byte needs holding.
  assign byte_s = (sel_s == HI) ? hi_r : mem_data[7:0];

  uart_byte_hs u_hs (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_s),
    .din   (byte_s),
    .ack   (uart_ack),
    .valid (uart_valid),
    .data  (uart_data),
    .xfer  (xfer_s)
  );

  // Next-state and control decode.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    load_s      = 1'b0;
    sel_s       = LO;
    addr_inc_s  = 1'b0;
    rem_dec_s   = 1'b0;
    abort_set_s = 1'b0;
    fin_abort_s = 1'b0;
    word_end_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          accept_s = 1'b1;
          if (cmd_len == ZERO) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = ADDR;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ADDR: begin
        if (abort) begin
          state_nxt_s = DONE;
          fin_abort_s = 1'b1;
        end else begin
          state_nxt_s = CAPT;
        end
      end
      CAPT: begin
        if (abort) begin
          state_nxt_s = DONE;
          fin_abort_s = 1'b1;
        end else begin
          load_s      = 1'b1;
          sel_s       = LO;
          state_nxt_s = TX_LO;
        end
      end
      TX_LO: begin
        if (xfer_s) begin
          if (!mode_r) begin
            word_end_s = 1'b1;
          end else if (abort || abort_pend_r) begin
            state_nxt_s = DONE;
            fin_abort_s = 1'b1;
          end else begin
            state_nxt_s = TX_HI;
          end
        end else begin
          abort_set_s = abort;
        end
      end
      TX_HI: begin
        // First TX_HI cycle is the mandatory idle gap; the high byte loads during it.
        if (!uart_valid) begin
          if (abort) begin
            state_nxt_s = DONE;
            fin_abort_s = 1'b1;
          end else begin
            load_s = 1'b1;
            sel_s  = HI;
          end
        end else if (xfer_s) begin
          word_end_s = 1'b1;
        end else begin
          abort_set_s = abort;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    // A same-cycle abort on the final byte still counts as normal completion.
    if (word_end_s) begin
      if (rem_r == ONE) begin
        state_nxt_s = DONE;
        fin_abort_s = abort_pend_r;
      end else if (abort || abort_pend_r) begin
        state_nxt_s = DONE;
        fin_abort_s = 1'b1;
      end else begin
        state_nxt_s = ADDR;
        addr_inc_s  = 1'b1;
        rem_dec_s   = 1'b1;
      end
    end else begin
      addr_inc_s = 1'b0;
      rem_dec_s  = 1'b0;
    end
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      busy_r    <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      state_r   <= state_nxt_s;
      done_r    <= (state_nxt_s == DONE);
      aborted_r <= (state_nxt_s == DONE) & fin_abort_s;
      busy_r    <= (state_nxt_s != IDLE);
      ready_r   <= (state_nxt_s == IDLE);
    end
  end

  // Address/remaining counters, mode bit, high-byte hold and pending abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r       <= ZERO;
      rem_r        <= ZERO;
      mode_r       <= 1'b0;
      hi_r         <= 8'h00;
      abort_pend_r <= 1'b0;
    end else begin
      // An empty command leaves the RAM address untouched.
      if (accept_s && (cmd_len != ZERO)) begin
        addr_r <= cmd_addr;
      end else if (addr_inc_s) begin
        addr_r <= addr_r + ONE;
      end
      if (accept_s) begin
        rem_r <= cmd_len;
      end else if (rem_dec_s) begin
        rem_r <= rem_r - ONE;
      end
      if (accept_s) begin
        mode_r <= cmd_both;
      end
      if (state_r == CAPT) begin
        hi_r <= mem_data[15:8];
      end
      if (accept_s) begin
        abort_pend_r <= 1'b0;
      end else if (abort_set_s) begin
        abort_pend_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_uart_dump_ctrl.sv
// Self-checking bench: command table plus scoreboard of expected bytes and RAM addresses.
module tb_mem_uart_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [13:0] cmd_addr;
  logic [13:0] cmd_len;
  logic        cmd_both;
  logic        abort;
  logic [13:0] mem_addr;
  logic [15:0] mem_data = 16'h0000;
  logic        uart_valid;
  logic [7:0]  uart_data;
  logic        uart_ack;
  logic        busy;
  logic        done;
  logic        aborted;

  int tot_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int ack_delay = 1;
  bit ack_hold  = 1'b0;

  logic [7:0]  exp_bytes[$];
  logic [13:0] exp_addrs[$];

  typedef struct {
    logic [13:0] addr;
    logic [13:0] len;
    logic        both;
    int          ack_dly;
    int          exp_rise;      // cycles from accept cycle to first uart_valid, -1 = never
    int          exp_done_lat;  // cycles from accept cycle to done, -1 = not checked
  } vec_t;

  vec_t vecs[5];

  mem_uart_dump_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_both   (cmd_both),
    .abort      (abort),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .uart_valid (uart_valid),
    .uart_data  (uart_data),
    .uart_ack   (uart_ack),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ram_word(input logic [13:0] a);
    return 16'hA500 + {2'b00, a};
  endfunction

  // Synchronous-read RAM model.
  always @(posedge clk) mem_data <= ram_word(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // UART sink: raises ack ack_delay cycles after valid, holds it one cycle.
  int ack_cnt = 0;
  initial begin
    uart_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        uart_ack = 1'b0;
        ack_cnt  = 0;
      end else if (uart_ack) begin
        uart_ack = 1'b0;
        ack_cnt  = 0;
      end else if (uart_valid && !ack_hold) begin
        ack_cnt++;
        if (ack_cnt > ack_delay) uart_ack = 1'b1;
      end else begin
        ack_cnt = 0;
      end
    end
  end

  // Protocol monitor and scoreboard pop side.
  logic        valid_prev = 1'b0;
  logic        xfer_prev  = 1'b0;
  logic [7:0]  data_prev  = 8'h00;
  logic [13:0] maddr_prev = 14'h0000;
  always @(negedge clk) begin
    if (!rst_n) begin
      valid_prev = 1'b0;
      xfer_prev  = 1'b0;
      maddr_prev = mem_addr;
    end else begin
      if (xfer_prev) begin
        chk("byte_gap", 32'(uart_valid), 32'd0);
      end else if (valid_prev) begin
        chk("valid_held", 32'(uart_valid), 32'd1);
        if (uart_valid) chk("data_stable", 32'(uart_data), 32'(data_prev));
      end
      if (uart_valid && uart_ack) begin
        if (exp_bytes.size() == 0) begin
          tot_cnt++;
          $display("FAIL extra_byte: got 0x%0h, want no byte", uart_data);
        end else begin
          chk("byte", 32'(uart_data), 32'(exp_bytes.pop_front()));
        end
      end
      if (busy && (mem_addr != maddr_prev)) begin
        if (exp_addrs.size() == 0) begin
          tot_cnt++;
          $display("FAIL extra_mem_addr: got 0x%0h, want no change", mem_addr);
        end else begin
          chk("mem_addr", 32'(mem_addr), 32'(exp_addrs.pop_front()));
        end
      end
      valid_prev = uart_valid;
      xfer_prev  = uart_valid && uart_ack;
      data_prev  = uart_data;
      maddr_prev = mem_addr;
    end
  end

  task automatic push_cmd(input logic [13:0] a, input logic [13:0] l, input logic b);
    for (int i = 0; i < int'(l); i++) begin
      logic [13:0] wa;
      logic [15:0] w;
      wa = a + 14'(i);
      w  = ram_word(wa);
      exp_addrs.push_back(wa);
      exp_bytes.push_back(w[7:0]);
      if (b) exp_bytes.push_back(w[15:8]);
    end
  endtask

  task automatic issue(input logic [13:0] a, input logic [13:0] l, input logic b);
    int k;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_both  = b;
    acc_cyc   = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output logic ab, output int rise_lat, output int done_lat);
    bit seen;
    seen = 1'b0;
    ab = 1'b0;
    rise_lat = -1;
    done_lat = -1;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (rise_lat < 0 && uart_valid) rise_lat = cyc - acc_cyc;
      if (done) begin
        seen     = 1'b1;
        ab       = aborted;
        done_lat = cyc - acc_cyc;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic after_done_checks(input string tag);
    @(negedge clk);
    chk({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, "_bytes_drained"}, 32'(exp_bytes.size()), 32'd0);
    chk({tag, "_addrs_drained"}, 32'(exp_addrs.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ab;
    int   rl, dl, n, k;

    vecs[0] = '{14'h0010, 14'd3, 1'b0, 1, 3, -1};
    vecs[1] = '{14'h0020, 14'd2, 1'b1, 5, 3, -1};
    vecs[2] = '{14'h3FFE, 14'd4, 1'b0, 1, 3, -1};
    vecs[3] = '{14'h0123, 14'd0, 1'b0, 1, -1, 1};
    vecs[4] = '{14'h0200, 14'd1, 1'b1, 0, 3, -1};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = 14'h0; cmd_len = 14'h0;
    cmd_both = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_uart_valid", 32'(uart_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_uart_data", 32'(uart_data), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      ack_delay = vecs[v].ack_dly;
      push_cmd(vecs[v].addr, vecs[v].len, vecs[v].both);
      issue(vecs[v].addr, vecs[v].len, vecs[v].both);
      wait_done(ab, rl, dl);
      chk("vec_aborted", 32'(ab), 32'd0);
      chk("vec_first_valid_lat", 32'(rl), 32'(vecs[v].exp_rise));
      if (vecs[v].exp_done_lat >= 0) chk("vec_done_lat", 32'(dl), 32'(vecs[v].exp_done_lat));
      after_done_checks("vec");
    end

    // Abort while the 3rd byte is pending: byte still goes, nothing after it.
    ack_delay = 1;
    push_cmd(14'h0040, 14'd3, 1'b0);
    issue(14'h0040, 14'd8, 1'b0);
    n = 0;
    for (k = 0; k < 200 && n < 2; k++) begin
      @(negedge clk);
      if (uart_valid && uart_ack) n++;
    end
    ack_hold = 1'b1;
    @(negedge clk);
    for (k = 0; k < 50 && !uart_valid; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_byte_still_pending", 32'(uart_valid), 32'd1);
    chk("abort_no_early_done", 32'(done), 32'd0);
    ack_hold = 1'b0;
    wait_done(ab, rl, dl);
    chk("abort_pending_aborted", 32'(ab), 32'd1);
    after_done_checks("abort_pending");

    // Abort while the sequencer is addressing the 2nd word.
    push_cmd(14'h0050, 14'd1, 1'b1);
    exp_addrs.push_back(14'h0051);
    issue(14'h0050, 14'd4, 1'b1);
    n = 0;
    for (k = 0; k < 200 && n < 2; k++) begin
      @(negedge clk);
      if (uart_valid && uart_ack) n++;
    end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_addr_done", 32'(done), 32'd1);
    chk("abort_addr_aborted", 32'(aborted), 32'd1);
    after_done_checks("abort_addr");

    // Reset mid-byte, then a fresh command from its own start address.
    ack_hold = 1'b1;
    exp_addrs.push_back(14'h0060);
    issue(14'h0060, 14'd4, 1'b1);
    for (k = 0; k < 50 && !uart_valid; k++) @(negedge clk);
    chk("pre_reset_valid", 32'(uart_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(uart_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    ack_hold = 1'b0;
    push_cmd(14'h0070, 14'd2, 1'b0);
    issue(14'h0070, 14'd2, 1'b0);
    wait_done(ab, rl, dl);
    chk("post_reset_aborted", 32'(ab), 32'd0);
    chk("post_reset_first_valid_lat", 32'(rl), 32'd3);
    after_done_checks("post_reset");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
